// File: rtl/mips_md_pkg.sv
// Shared definitions for the MIPS HI/LO multiply-divide unit: FSM states, widths,
// the fixed divide latency and the {HI, LO} field positions.
package mips_md_pkg;

    localparam int MD_WIDTH    = 32;
    localparam int DIV_LATENCY = 34;

    localparam int HI_MSB = 63;
    localparam int HI_LSB = 32;
    localparam int LO_MSB = 31;
    localparam int LO_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 division step: shift in a dividend bit and subtract the
// divisor if the shifted partial remainder is large enough.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_nxt,
    output logic             qbit
);

    logic [WIDTH:0] trial;

    assign trial = {rem, bit_in};
    assign qbit  = (trial >= {1'b0, dvs});
    // The restored remainder is always below dvs, so a WIDTH-bit modular subtract suffices.
    assign rem_nxt = qbit ? (trial[WIDTH-1:0] - dvs) : trial[WIDTH-1:0];

endmodule

// File: rtl/divu_iter.sv
// Iterative restoring divider for DIV/DIVU: 32 RUN steps, one FIX cycle for sign
// correction, then a one-cycle DONE pulse with {remainder, quotient} on y.
module divu_iter
    import mips_md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               sign,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               flush,
    output logic               busy,
    output logic               done,
    output logic               dz,
    output logic [2*WIDTH-1:0] y
);

    localparam int CW = $clog2(WIDTH);

    md_state_e state, state_nxt;

    logic [CW-1:0]           cnt;
    logic [WIDTH-1:0]        a_raw, dvd, dvs, rem, rem_nxt;
    logic [WIDTH-1:0]        a_mag, b_mag, q_fix, r_fix;
    logic signed [WIDTH-1:0] a_s, b_s;
    logic                    neg_q, neg_r, qbit, accept, last_step;

    function automatic logic [WIDTH-1:0] neg_if(input logic n, input logic [WIDTH-1:0] v);
        return n ? (~v + 1'b1) : v;
    endfunction

    assign a_s   = a;
    assign b_s   = b;
    assign a_mag = neg_if(sign && a_s[WIDTH-1], a);
    assign b_mag = neg_if(sign && b_s[WIDTH-1], b);

    assign accept    = start && !flush && (state == IDLE || state == DONE);
    assign last_step = (cnt == CW'(WIDTH - 1));

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem    (rem),
        .bit_in (dvd[WIDTH-1]),
        .dvs    (dvs),
        .rem_nxt(rem_nxt),
        .qbit   (qbit)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = RUN;
            RUN: begin
                if (flush)          state_nxt = IDLE;
                else if (last_step) state_nxt = FIX;
            end
            FIX:  state_nxt = flush ? IDLE : DONE;
            DONE: state_nxt = accept ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch and iteration; dvd doubles as the quotient shift register.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_raw <= a;
            dvd   <= a_mag;
            dvs   <= b_mag;
            rem   <= '0;
            cnt   <= '0;
            neg_q <= sign && (a_s[WIDTH-1] ^ b_s[WIDTH-1]);
            neg_r <= sign && a_s[WIDTH-1];
        end else if (state == RUN) begin
            rem <= rem_nxt;
            dvd <= {dvd[WIDTH-2:0], qbit};
            cnt <= cnt + 1'b1;
        end
    end

    assign q_fix = neg_if(neg_q, dvd);
    assign r_fix = neg_if(neg_r, rem);

    always_ff @(posedge clk) begin
        if (rst) begin
            y  <= '0;
            dz <= 1'b0;
        end else if (state == FIX && !flush) begin
            if (dvs == '0) begin
                y[HI_MSB:HI_LSB] <= a_raw;
                y[LO_MSB:LO_LSB] <= '1;
                dz               <= 1'b1;
            end else begin
                y[HI_MSB:HI_LSB] <= r_fix;
                y[LO_MSB:LO_LSB] <= q_fix;
                dz               <= 1'b0;
            end
        end
    end

    assign busy = (state == RUN) || (state == FIX);
    assign done = (state == DONE);

endmodule

// File: tb/tb_divu_iter.sv
// Bench for divu_iter: cycle-level behavioural model plus directed literal cases
// and randomized operations with start noise and flushes.
module tb_divu_iter;
    import mips_md_pkg::*;

    localparam int W = MD_WIDTH;

    logic           clk = 1'b0;
    logic           rst, start, sign, flush;
    logic [W-1:0]   a, b;
    logic           busy, done, dz;
    logic [2*W-1:0] y;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    divu_iter dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .sign (sign),
        .a    (a),
        .b    (b),
        .flush(flush),
        .busy (busy),
        .done (done),
        .dz   (dz),
        .y    (y)
    );

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference result {dz, remainder, quotient} from plain integer arithmetic.
    function automatic logic [64:0] model_div(input logic sg, input logic [31:0] aa, input logic [31:0] bb);
        longint sa, sb, q, r;
        if (bb == 0) return {1'b1, aa, 32'hFFFF_FFFF};
        if (!sg) return {1'b0, aa % bb, aa / bb};
        sa = longint'($signed(aa));
        sb = longint'($signed(bb));
        q  = sa / sb;
        r  = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
    endfunction

    // Model: operation age in cycles since the accepting edge.
    bit          in_flight = 0, model_ok = 0;
    int          age = 0;
    logic [64:0] pend;
    logic [63:0] exp_y = '0;
    logic        exp_dz = 1'b0;

    always @(posedge clk) begin
        bit pre_busy, pre_done;
        if (rst) begin
            in_flight = 0;
            exp_y     = '0;
            exp_dz    = 1'b0;
            model_ok  = 1;
        end else begin
            pre_busy = in_flight && age <= DIV_LATENCY - 1;
            pre_done = in_flight && age == DIV_LATENCY;
            if (in_flight) age++;
            if (pre_busy && flush) in_flight = 0;
            else if (pre_busy && age == DIV_LATENCY) begin
                exp_y  = pend[63:0];
                exp_dz = pend[64];
            end
            if (pre_done) in_flight = 0;
            if (!pre_busy && start && !flush) begin
                in_flight = 1;
                age       = 1;
                pend      = model_div(sign, a, b);
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("busy", busy, in_flight && age <= DIV_LATENCY - 1);
            check("done", done, in_flight && age == DIV_LATENCY);
            check("y",    y,    exp_y);
            check("dz",   dz,   exp_dz);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic sg, input logic [31:0] aa, input logic [31:0] bb);
        sign  = sg;
        a     = aa;
        b     = bb;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // k0 is the age of the next negedge; returns just after the done negedge.
    task automatic wait_done(input string name, input int k0, input logic [63:0] ey, input logic edz);
        int  k    = k0;
        bit  seen = 0;
        while (!seen && k <= DIV_LATENCY + 6) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
            else k++;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no done expected done at %0d", name, DIV_LATENCY);
        end else begin
            check({name, "_lat"}, k, DIV_LATENCY);
            check({name, "_y"}, y, ey);
            check({name, "_dz"}, dz, edz);
        end
    endtask

    task automatic run_op(input string name, input logic sg, input logic [31:0] aa,
                          input logic [31:0] bb, input logic [63:0] ey, input logic edz);
        launch(sg, aa, bb);
        wait_done(name, 1, ey, edz);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sign = 1'b0; flush = 1'b0; a = '0; b = '0;

        check("pin_divu", model_div(1'b0, 32'd100, 32'd7), {1'b0, 32'd2, 32'd14});
        check("pin_div_neg", model_div(1'b1, 32'hFFFF_FFF9, 32'd2), {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        check("pin_div_ovf", model_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF), {1'b0, 32'd0, 32'h8000_0000});
        check("pin_dz", model_div(1'b0, 32'h1234, 32'd0), {1'b1, 32'h1234, 32'hFFFF_FFFF});

        repeat (3) tick();
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", dz, 0);
        check("rst_y", y, 0);
        tick();
        rst = 1'b0;
        tick();

        run_op("divu", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);
        run_op("div_neg", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
        run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1'b0);
        run_op("dz", 1'b0, 32'h1234, 32'd0, {32'h1234, 32'hFFFF_FFFF}, 1'b1);
        run_op("dz_clear", 1'b0, 32'd10, 32'd3, {32'd1, 32'd3}, 1'b0);
        tick();

        // Second start while busy must not disturb the first operation.
        launch(1'b0, 32'd50, 32'd5);
        repeat (3) tick();
        a = 32'd99; b = 32'd3; sign = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("busy_ign", 5, {32'd0, 32'd10}, 1'b0);
        repeat (3) tick();

        // Flush mid-run: idle next cycle, result registers untouched.
        launch(1'b0, 32'd1000, 32'd10);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy", busy, 0);
        check("flush_y", y, {32'd0, 32'd10});
        run_op("after_flush", 1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 1'b0);
        tick();

        // Reset mid-run clears everything.
        launch(1'b0, 32'd77, 32'd0);
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_y", y, 0);
        check("midrst_dz", dz, 0);
        tick();

        // Back-to-back: start accepted in the DONE cycle.
        launch(1'b0, 32'd100, 32'd7);
        wait_done("b2b_first", 1, {32'd2, 32'd14}, 1'b0);
        sign = 1'b1; a = 32'hFFFF_FF9C; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("b2b_second", 1, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 1'b0);

        for (int i = 0; i < 300; i++) begin
            int n;
            sign = 1'($urandom_range(0, 1));
            a    = $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFF_FFFF;
                3:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: b = $urandom;
            endcase
            start = 1'b1;
            tick();
            start = 1'b0;
            a = $urandom;
            b = $urandom;
            n = $urandom_range(20, 40);
            repeat (n) begin
                flush = ($urandom_range(0, 99) == 0);
                start = ($urandom_range(0, 15) == 0);
                tick();
            end
            flush = 1'b0;
            start = 1'b0;
        end
        repeat (40) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/divu_iter.md
# divu_iter

Iterative 32-bit divider for the MIPS HI/LO multiply-divide unit; the division counterpart of the combinational unsigned multiplier. Accepts a dividend/divisor pair on a start pulse, runs a restoring radix-2 loop one quotient bit per cycle, and returns `{remainder, quotient}` in the same `{HI, LO}` 64-bit layout the multiplier produces. Serves DIVU and, via a sign input, DIV; the EX stage stalls on `busy` and retires on `done`.

## Interface
- `WIDTH`, 32: operand width; `y` is `2*WIDTH`.
- `clk`  in  1  rising-edge clock, sole clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `sign`  in  1  0 = DIVU (unsigned), 1 = DIV (two's complement); latched with `start`.
- `a`  in  WIDTH  dividend; latched with `start`.
- `b`  in  WIDTH  divisor; latched with `start`.
- `flush`  in  1  pipeline flush; aborts an operation in flight.
- `busy`  out  1  high while an operation is in flight (RUN, FIX).
- `done`  out  1  one-cycle pulse; `y` and `dz` valid.
- `dz`  out  1  divide-by-zero flag for the last completed operation.
- `y`  out  2*WIDTH  `{remainder[63:32], quotient[31:0]}`; held until next completion.

## Operation
- States: IDLE, RUN, FIX, DONE.
  - IDLE: `start` latches `a`, `b`, `sign`, clears counter → RUN.
  - RUN: one restoring step per cycle; after 32 steps → FIX.
  - FIX: sign correction, `y`/`dz` register write → DONE.
  - DONE: `done`=1 for one cycle, then → IDLE.
  - `start` in DONE is accepted exactly as in IDLE, giving back-to-back operation.
- Signed mode:
  - Operands are converted to magnitudes on latch.
  - The quotient is negated if the operand signs differ.
  - The remainder takes the sign of the dividend, so the quotient truncates toward zero.
- Overflow: `0x80000000 / 0xFFFFFFFF` (signed) yields q=`0x80000000`, r=0, with no flag.
- Divide by zero (`b`=0), either mode:
  - Full latency is kept.
  - `y = {a, 32'hFFFFFFFF}` using raw latched `a`; `dz`=1.
  - `dz`=0 on every other completion.
- `start` while `busy`=1 is ignored; latched operands are unchanged.
- `flush` in RUN or FIX → IDLE next edge; no `done`; `y`/`dz` keep their previous values.
  - `flush` in IDLE or DONE has no effect, except that `start` in the same cycle is dropped.
  - `flush` has priority over `start`.
- `rst` (synchronous) has priority over everything → IDLE.
  - Outputs after reset: `busy`=0, `done`=0, `dz`=0, `y`=0.
  - Any operation in flight is discarded.

## Timing
- `start` sampled at edge N: `busy`=1 in cycles N+1..N+33; `done`=1, `busy`=0 in cycle N+34.
  - Fixed latency of 34 cycles, independent of operand values and mode.
- `y`/`dz` update at the same edge that raises `done`, and are stable from that cycle onward.
- No combinational path from inputs to outputs; all outputs are registered.
- Accepting `start` in the DONE cycle gives throughput of one result per 34 cycles.

## Structure
- Shared package `mips_md_pkg` holds:
  - the state enum (IDLE/RUN/FIX/DONE);
  - `MD_WIDTH`=32;
  - `DIV_LATENCY`=34;
  - the `{HI, LO}` field index constants, also used by the multiplier.
- Sub-module `div_step` (combinational): one restoring step.
  - Inputs: partial remainder, dividend bit, divisor.
  - Outputs: next partial remainder, quotient bit.
  - Instantiated once, iterated by the FSM.

## Test plan
- Unsigned: DIVU `a`=100, `b`=7 → `done` exactly 34 cycles after `start`; `y`=`{32'd2, 32'd14}`; `dz`=0.
- Signed: DIV `a`=`0xFFFFFFF9` (−7), `b`=2 → q=`0xFFFFFFFD`, r=`0xFFFFFFFF`. DIV `a`=`0x80000000`, `b`=`0xFFFFFFFF` → q=`0x80000000`, r=0, `dz`=0.
- Divide by zero: DIVU `a`=`0x1234`, `b`=0 → `y`=`{32'h1234, 32'hFFFFFFFF}`, `dz`=1 after 34 cycles. Next valid divide clears `dz`.
- Start while busy: second `start` at cycle N+5 with different operands → ignored; a single `done` at N+34 carries the first result.
- Flush and reset mid-operation:
  - `flush` at N+10 → `busy`=0 at N+11, no `done`, `y` unchanged; a new `start` then completes normally.
  - `rst` at N+20 → all outputs 0 next cycle.
- Back-to-back: `start` asserted in a DONE cycle → accepted; second `done` arrives 34 cycles later with the correct second result.
